// File: rtl/fc_pkg.sv
// fc_pkg
// Shared constants and helpers for the multi-lane fast-control serializer.
//   WORD_W_DEF    : default word length in bits (also the frame length in cycles)
//   IDLE_WORD_DEF : default pattern sent on a lane that has no pending command
//   MAX_DLY_DEF   : default maximum per-lane deskew delay in cycles
//   dly_w()       : width of one per-lane delay field for a given maximum delay
package fc_pkg;

  localparam int         WORD_W_DEF    = 8;
  localparam logic [7:0] IDLE_WORD_DEF = 8'hAC;
  localparam int         MAX_DLY_DEF   = 15;

  // Width needed to encode 0..max_dly; never narrower than one bit.
  function automatic int dly_w(input int max_dly);
    return (max_dly < 1) ? 1 : $clog2(max_dly + 1);
  endfunction

endpackage

// File: rtl/fc_chan_ser.sv
// fc_chan_ser
// One serial lane: single-entry command hold register, word shift register,
// deskew delay line and output polarity inversion.
// Ports:
//   fc_clk_i, fc_rst_n_i : bit clock, asynchronous active-low reset
//   load_i               : high in the last cycle of a frame; the edge ending it loads a word
//   rst_done_i           : high from the first edge after reset release
//   cmd_valid_i/_data_i  : command word offered to this lane
//   cmd_ready_o          : hold register can accept a word
//   ch_en_i              : lane enable (static config)
//   ch_inv_i             : output polarity inversion (static config)
//   ch_dly_i             : extra output delay in cycles (static config)
//   fc_sig_o             : registered serial output bit
module fc_chan_ser
  import fc_pkg::*;
#(
  parameter int               WORD_W    = WORD_W_DEF,
  parameter logic [WORD_W-1:0] IDLE_WORD = IDLE_WORD_DEF,
  parameter int               MAX_DLY   = MAX_DLY_DEF,
  parameter int               DLY_W     = dly_w(MAX_DLY)
) (
  input  logic              fc_clk_i,
  input  logic              fc_rst_n_i,
  input  logic              load_i,
  input  logic              rst_done_i,
  input  logic              cmd_valid_i,
  input  logic [WORD_W-1:0] cmd_data_i,
  output logic              cmd_ready_o,
  input  logic              ch_en_i,
  input  logic              ch_inv_i,
  input  logic [DLY_W-1:0]  ch_dly_i,
  output logic              fc_sig_o
);

  localparam logic [DLY_W-1:0] DLY_SEL_MAX = DLY_W'(MAX_DLY);

  logic              hold_vld_reg;
  logic [WORD_W-1:0] hold_data_reg;
  logic [WORD_W-1:0] shift_reg;
  logic              active_reg;
  logic [MAX_DLY-1:0] dly_line_reg;
  logic              fc_sig_reg;

  logic               ser_bit;
  logic [MAX_DLY:0]   taps;
  logic [DLY_W-1:0]   dly_sel;

  assign cmd_ready_o = rst_done_i && !hold_vld_reg;

  // active_reg gates the lane output: it drops as soon as the lane is
  // disabled and only comes back at a frame boundary, so a lane re-enabled
  // mid-frame keeps sending zeros until a whole word is lined up.
  assign ser_bit = active_reg & shift_reg[WORD_W-1];

  // taps[0] is the undelayed bit, taps[n] the bit delayed by n cycles.
  assign taps    = {dly_line_reg, ser_bit};
  assign dly_sel = (ch_dly_i > DLY_SEL_MAX) ? DLY_SEL_MAX : ch_dly_i;

  always_ff @(posedge fc_clk_i or negedge fc_rst_n_i) begin
    if (!fc_rst_n_i) begin
      hold_vld_reg  <= 1'b0;
      hold_data_reg <= '0;
      shift_reg     <= '0;
      active_reg    <= 1'b0;
      dly_line_reg  <= '0;
      fc_sig_reg    <= 1'b0;
    end else begin
      // Hold register: a disabled lane accepts and drops words.
      if (!ch_en_i) begin
        hold_vld_reg <= 1'b0;
      end else if (load_i && hold_vld_reg) begin
        hold_vld_reg <= 1'b0;
      end else if (cmd_valid_i && cmd_ready_o) begin
        hold_vld_reg  <= 1'b1;
        hold_data_reg <= cmd_data_i;
      end

      if (load_i) begin
        shift_reg <= (ch_en_i && hold_vld_reg) ? hold_data_reg : IDLE_WORD;
      end else begin
        shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
      end

      if (!ch_en_i) begin
        active_reg <= 1'b0;
      end else if (load_i) begin
        active_reg <= 1'b1;
      end

      dly_line_reg <= taps[MAX_DLY-1:0];
      fc_sig_reg   <= taps[dly_sel] ^ ch_inv_i;
    end
  end

  assign fc_sig_o = fc_sig_reg;

endmodule

// File: rtl/fast_control_serializer.sv
// fast_control_serializer
// Multi-lane fast-control serializer. Each lane takes command words over a
// valid/ready handshake and sends them MSB-first, one bit per clock, on a
// frame grid shared by all lanes; lanes with nothing to send emit IDLE_WORD.
// Ports:
//   fc_clk_i, fc_rst_n_i : bit clock, asynchronous active-low reset
//   cmd_valid_i          : per-lane command valid
//   cmd_data_i           : per-lane command words, lane k at [k*WORD_W +: WORD_W]
//   cmd_ready_o          : per-lane ready
//   ch_en_i, ch_inv_i    : per-lane enable and polarity inversion
//   ch_dly_i             : per-lane deskew delay, lane k at [k*DLY_W +: DLY_W]
//   frame_o              : pulse on the first cycle of each frame in the shift registers
//   fc_sig_o             : per-lane registered serial bit
module fast_control_serializer
  import fc_pkg::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                WORD_W    = WORD_W_DEF,
  parameter logic [WORD_W-1:0] IDLE_WORD = IDLE_WORD_DEF,
  parameter int                MAX_DLY   = MAX_DLY_DEF,
  parameter int                DLY_W     = dly_w(MAX_DLY)
) (
  input  logic                     fc_clk_i,
  input  logic                     fc_rst_n_i,
  input  logic [NUM_CH-1:0]        cmd_valid_i,
  input  logic [NUM_CH*WORD_W-1:0] cmd_data_i,
  output logic [NUM_CH-1:0]        cmd_ready_o,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic [NUM_CH-1:0]        ch_inv_i,
  input  logic [NUM_CH*DLY_W-1:0]  ch_dly_i,
  output logic                     frame_o,
  output logic [NUM_CH-1:0]        fc_sig_o
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0] bit_cnt_reg;
  logic             frame_reg;
  logic             rst_done_reg;
  logic             load;

  // The edge that ends the last cycle of a frame loads every shift register.
  assign load = (bit_cnt_reg == CNT_LAST);

  always_ff @(posedge fc_clk_i or negedge fc_rst_n_i) begin
    if (!fc_rst_n_i) begin
      bit_cnt_reg  <= '0;
      frame_reg    <= 1'b0;
      rst_done_reg <= 1'b0;
    end else begin
      bit_cnt_reg  <= load ? '0 : bit_cnt_reg + CNT_W'(1);
      frame_reg    <= load;
      rst_done_reg <= 1'b1;
    end
  end

  assign frame_o = frame_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    fc_chan_ser #(
      .WORD_W    (WORD_W),
      .IDLE_WORD (IDLE_WORD),
      .MAX_DLY   (MAX_DLY),
      .DLY_W     (DLY_W)
    ) u_chan (
      .fc_clk_i    (fc_clk_i),
      .fc_rst_n_i  (fc_rst_n_i),
      .load_i      (load),
      .rst_done_i  (rst_done_reg),
      .cmd_valid_i (cmd_valid_i[gi]),
      .cmd_data_i  (cmd_data_i[gi*WORD_W +: WORD_W]),
      .cmd_ready_o (cmd_ready_o[gi]),
      .ch_en_i     (ch_en_i[gi]),
      .ch_inv_i    (ch_inv_i[gi]),
      .ch_dly_i    (ch_dly_i[gi*DLY_W +: DLY_W]),
      .fc_sig_o    (fc_sig_o[gi])
    );
  end

endmodule

// File: tb/tb_fast_control_serializer.sv
// tb_fast_control_serializer
// Directed bench for fast_control_serializer (4 lanes, 8-bit words, idle 0xAC).
// Cycle n is the n-th clock period after reset release; cycle 0 ends at the
// first rising edge. Every comparison is made 1 ns after a rising edge.
module tb_fast_control_serializer;

  localparam logic [7:0] IDLE = 8'hAC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cmd_valid;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_ready;
  logic [3:0]  ch_en;
  logic [3:0]  ch_inv;
  logic [15:0] ch_dly;
  logic        frame;
  logic [3:0]  fc_sig;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  fast_control_serializer dut (
    .fc_clk_i    (clk),
    .fc_rst_n_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_data_i  (cmd_data),
    .cmd_ready_o (cmd_ready),
    .ch_en_i     (ch_en),
    .ch_inv_i    (ch_inv),
    .ch_dly_i    (ch_dly),
    .frame_o     (frame),
    .fc_sig_o    (fc_sig)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Bit of word w that is on a zero-delay output in cycle c of a word that
  // started 1 cycle after a frame pulse; d shifts it later by d cycles.
  function automatic logic word_bit(input logic [7:0] w, input int c, input int d);
    int i;
    i = 7 - ((c - 1 - d) % 8);
    return w[i];
  endfunction

  // Steady-state output of all lanes when every lane sends IDLE.
  function automatic logic [3:0] idle_vec(input int c);
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      int d;
      d = int'(ch_dly[k*4 +: 4]);
      v[k] = word_bit(IDLE, c, d) ^ ch_inv[k];
    end
    return v;
  endfunction

  // Output of all lanes in cycle c after a reset release with no commands.
  function automatic logic [3:0] reset_vec(input int c);
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      int d;
      d = int'(ch_dly[k*4 +: 4]);
      if (c < 9 + d) v[k] = ch_inv[k];
      else           v[k] = word_bit(IDLE, c, d) ^ ch_inv[k];
    end
    return v;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = '0;
    cmd_data  = '0;
    ch_en     = 4'hF;
    ch_inv    = 4'hF;
    ch_dly    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fc_sig !== 4'h0) begin
      errors++; $display("FAIL reset_fc_sig: got %h expected %h", fc_sig, 4'h0);
    end
    checks++;
    if (cmd_ready !== 4'h0) begin
      errors++; $display("FAIL reset_ready: got %h expected %h", cmd_ready, 4'h0);
    end
    checks++;
    if (frame !== 1'b0) begin
      errors++; $display("FAIL reset_frame: got %b expected %b", frame, 1'b0);
    end
    ch_inv = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    #1;
    checks++;
    if (cmd_ready !== 4'h0) begin
      errors++; $display("FAIL reset_ready_cycle0: got %h expected %h", cmd_ready, 4'h0);
    end
  endtask

  task automatic test_idle();
    for (int n = 0; n < 24; n++) begin
      tick();
      checks++;
      if (frame !== (cyc % 8 == 0)) begin
        errors++; $display("FAIL idle_frame cycle %0d: got %b expected %b", cyc, frame, (cyc % 8 == 0));
      end
      checks++;
      if (fc_sig !== reset_vec(cyc)) begin
        errors++; $display("FAIL idle_fc_sig cycle %0d: got %b expected %b", cyc, fc_sig, reset_vec(cyc));
      end
      checks++;
      if (cmd_ready !== 4'hF) begin
        errors++; $display("FAIL idle_ready cycle %0d: got %h expected %h", cyc, cmd_ready, 4'hF);
      end
    end
  endtask

  task automatic test_single_command();
    int base;
    logic [3:0] exp;
    base = cyc;
    repeat (3) tick();
    cmd_valid[0]   = 1'b1;
    cmd_data[7:0]  = 8'h5A;
    checks++;
    if (cmd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL single_ready_before: got %b expected %b", cmd_ready[0], 1'b1);
    end
    tick();
    cmd_valid[0] = 1'b0;
    $display("txn ch0 word 5a accepted at cycle %0d", cyc - 1);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (cmd_ready[0] !== 1'b0) begin
        errors++; $display("FAIL single_ready_low cycle %0d: got %b expected %b", cyc, cmd_ready[0], 1'b0);
      end
      if (n < 3) tick();
    end
    tick();
    checks++;
    if (cmd_ready[0] !== 1'b1 || frame !== 1'b1) begin
      errors++; $display("FAIL single_ready_return cycle %0d: got ready=%b frame=%b expected 1 1", cyc, cmd_ready[0], frame);
    end
    for (int n = 0; n < 16; n++) begin
      tick();
      exp = idle_vec(cyc);
      if (cyc <= base + 16) exp[0] = word_bit(8'h5A, cyc, 0);
      checks++;
      if (fc_sig !== exp) begin
        errors++; $display("FAIL single_fc_sig cycle %0d: got %b expected %b", cyc, fc_sig, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic [3:0] exp;
    logic       hs;
    logic       exp_rdy;
    int         idx;
    int         base;
    words = '{8'h11, 8'h22, 8'h33};
    base  = cyc;
    idx   = 0;
    cmd_valid[1]    = 1'b1;
    cmd_data[15:8]  = words[0];
    for (int rel = 1; rel <= 40; rel++) begin
      hs = cmd_ready[1] && cmd_valid[1];
      tick();
      if (hs) begin
        $display("txn ch1 word %h accepted at cycle %0d", words[idx], cyc - 1);
        idx++;
        if (idx < 3) cmd_data[15:8] = words[idx];
        else         cmd_valid[1]   = 1'b0;
      end
      exp_rdy = (rel % 8 == 0) || (rel >= 24);
      checks++;
      if (cmd_ready[1] !== exp_rdy) begin
        errors++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", cyc, cmd_ready[1], exp_rdy);
      end
      exp = idle_vec(cyc);
      if (rel >= 9 && rel <= 32) exp[1] = word_bit(words[(rel - 9) / 8], cyc, 0);
      checks++;
      if (fc_sig !== exp) begin
        errors++; $display("FAIL b2b_fc_sig cycle %0d: got %b expected %b", cyc, fc_sig, exp);
      end
    end
    checks++;
    if (idx !== 3) begin
      errors++; $display("FAIL b2b_accept_count: got %0d expected %0d", idx, 3);
    end
    if (cyc != base + 40) $display("note: b2b ended off frame grid");
  endtask

  task automatic test_deskew_invert();
    ch_en[2]      = 1'b0;
    ch_dly[11:8]  = 4'd3;
    ch_inv[3]     = 1'b1;
    tick();
    ch_en[2] = 1'b1;
    repeat (10) tick();
    for (int n = 0; n < 24; n++) begin
      tick();
      checks++;
      if (fc_sig !== idle_vec(cyc)) begin
        errors++; $display("FAIL deskew_fc_sig cycle %0d: got %b expected %b", cyc, fc_sig, idle_vec(cyc));
      end
    end
    repeat (5) tick();
  endtask

  task automatic test_disable_reenable();
    logic [3:0] exp;
    ch_en[0]      = 1'b0;
    cmd_valid[0]  = 1'b1;
    cmd_data[7:0] = 8'h77;
    checks++;
    if (cmd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL dis_ready_before: got %b expected %b", cmd_ready[0], 1'b1);
    end
    for (int rel = 1; rel <= 24; rel++) begin
      tick();
      exp = idle_vec(cyc);
      if (rel >= 2 && rel <= 16) exp[0] = 1'b0;
      checks++;
      if (fc_sig !== exp) begin
        errors++; $display("FAIL dis_fc_sig cycle %0d: got %b expected %b", cyc, fc_sig, exp);
      end
      checks++;
      if (cmd_ready[0] !== 1'b1) begin
        errors++; $display("FAIL dis_ready cycle %0d: got %b expected %b", cyc, cmd_ready[0], 1'b1);
      end
      if (rel == 11) begin
        cmd_valid[0] = 1'b0;
        ch_en[0]     = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_word();
    cmd_valid[1]   = 1'b1;
    cmd_data[15:8] = 8'h99;
    tick();
    cmd_valid[1] = 1'b0;
    $display("txn ch1 word 99 accepted at cycle %0d", cyc - 1);
    repeat (7) tick();
    checks++;
    if (cmd_ready[1] !== 1'b1) begin
      errors++; $display("FAIL rmw_ready_free: got %b expected %b", cmd_ready[1], 1'b1);
    end
    cmd_valid[1]   = 1'b1;
    cmd_data[15:8] = 8'h66;
    tick();
    cmd_valid[1] = 1'b0;
    $display("txn ch1 word 66 accepted at cycle %0d", cyc - 1);
    repeat (3) tick();
    checks++;
    if (cmd_ready[1] !== 1'b0) begin
      errors++; $display("FAIL rmw_hold_full: got %b expected %b", cmd_ready[1], 1'b0);
    end
    checks++;
    if (fc_sig[1] !== word_bit(8'h99, cyc, 0)) begin
      errors++; $display("FAIL rmw_mid_word: got %b expected %b", fc_sig[1], word_bit(8'h99, cyc, 0));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fc_sig !== 4'h0 || cmd_ready !== 4'h0 || frame !== 1'b0) begin
      errors++; $display("FAIL rmw_async_clear: got sig=%h rdy=%h frame=%b expected 0 0 0", fc_sig, cmd_ready, frame);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    #1;
    checks++;
    if (cmd_ready !== 4'h0) begin
      errors++; $display("FAIL rmw_ready_cycle0: got %h expected %h", cmd_ready, 4'h0);
    end
    for (int n = 0; n < 24; n++) begin
      tick();
      checks++;
      if (frame !== (cyc % 8 == 0)) begin
        errors++; $display("FAIL rmw_frame cycle %0d: got %b expected %b", cyc, frame, (cyc % 8 == 0));
      end
      checks++;
      if (fc_sig !== reset_vec(cyc)) begin
        errors++; $display("FAIL rmw_fc_sig cycle %0d: got %b expected %b", cyc, fc_sig, reset_vec(cyc));
      end
      checks++;
      if (cmd_ready !== 4'hF) begin
        errors++; $display("FAIL rmw_ready cycle %0d: got %h expected %h", cyc, cmd_ready, 4'hF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_command();
    test_back_to_back();
    test_deskew_invert();
    test_disable_reenable();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fast_control_serializer.md
# fast_control_serializer

Multi-channel successor to the single-lane fast-control driver. It accepts command words per channel over a valid/ready handshake and serialises them MSB-first, one bit per `fc_clk_i` cycle. All channels share one frame-aligned word counter. Each channel sends `IDLE_WORD` when it has no command, and has its own enable, bit-delay deskew and polarity inversion. Outputs are single-ended registered bits that feed the differential output buffers in the pad wrapper.

## Interface
- `NUM_CH`, 4: number of independent serial lanes
- `WORD_W`, 8: bits per command word / frame length in cycles (≥2)
- `IDLE_WORD`, 8'hAC: pattern sent when no command is pending (`WORD_W` bits)
- `MAX_DLY`, 15: maximum per-channel output delay in cycles
- `DLY_W`, `$clog2(MAX_DLY+1)`: width of one delay field
- `fc_clk_i` input 1: fast-control bit clock; the block's only clock
- `fc_rst_n_i` input 1: reset, asynchronous and active-low
- `cmd_valid_i` input NUM_CH: per-channel command valid
- `cmd_data_i` input NUM_CH*WORD_W: per-channel command word; channel k is in bits [k*WORD_W +: WORD_W]
- `cmd_ready_o` output NUM_CH: per-channel ready; transfer when valid&&ready at a rising edge
- `ch_en_i` input NUM_CH: per-channel enable (static config)
- `ch_inv_i` input NUM_CH: per-channel output polarity inversion (static config)
- `ch_dly_i` input NUM_CH*DLY_W: per-channel extra output delay, 0..MAX_DLY cycles (static config)
- `frame_o` output 1: one-cycle pulse marking the first cycle of every frame in the shift registers
- `fc_sig_o` output NUM_CH: registered serial bit per channel

## Operation
- Shared `bit_cnt`, 0..WORD_W-1, is free-running from reset release and wraps at WORD_W-1. A load edge is the edge ending a cycle with `bit_cnt==WORD_W-1`.
- Per-channel hold register (`hold_vld`, `hold_data`) has one entry. `cmd_ready_o[k] = rst_done && !hold_vld[k]`, where `rst_done` is a flop set on the first edge after reset release.
- On a load edge:
  - If the channel is enabled and `hold_vld` is set, the shift register takes `hold_data` and `hold_vld` clears.
  - Otherwise the shift register takes `IDLE_WORD`.
  - A handshake at the same edge is not possible: ready is low while the hold register is full.
- On other edges the shift register shifts left and the MSB feeds the delay line.
- Throughput is one word per frame per channel with no idle gap when valid is held continuously. Ready returns the cycle after each load edge.
- Disabled channel (`ch_en_i[k]=0`):
  - `hold_vld` clears immediately.
  - Ready is 1 (after `rst_done`), and accepted words are discarded.
  - The serial bit is forced to 0 before inversion.
  - Re-enabling takes effect at the next load edge; the partial frame stays 0.
- Delay line: a MAX_DLY-deep shift register per channel, with the tap selected by `ch_dly_i`. Changing `ch_dly_i` mid-stream may duplicate or drop bits; software reconfigures only while the channel is disabled.
- `fc_sig_o[k] <= tap ^ ch_inv_i[k]`.

## Timing
- Reset values:
  - `bit_cnt=0`, `hold_vld=0`, shift registers 0, delay lines 0, `rst_done=0`.
  - `frame_o=0`, `cmd_ready_o=0`, `fc_sig_o=0`. `fc_sig_o` is 0 during reset regardless of `ch_inv_i`; inversion applies from the first edge after release.
- `frame_o <= (bit_cnt==WORD_W-1)`. The first pulse comes WORD_W cycles after reset release, then every WORD_W cycles.
- Latency: the word's MSB appears on `fc_sig_o` 1+`ch_dly_i` cycles after the `frame_o` cycle. The LSB follows WORD_W-1 cycles later.
- Reset asserted mid-frame: everything clears asynchronously and pending hold contents are lost. Framing restarts from `bit_cnt=0`.

## Structure
- Package `fc_pkg` holds:
  - The default `WORD_W` and `IDLE_WORD` constants.
  - A `dly_w(max)` function returning the delay-field width.
- Sub-module `fc_chan_ser` covers one channel: hold register, shift register, delay line and inversion. The top instantiates it NUM_CH times via generate and owns `bit_cnt`, `frame_o` and `rst_done`.

## Test plan
- **Idle after reset.** Reset, no commands, dly=0, inv=0. All lanes repeat 10101100. The MSB lands 1 cycle after each `frame_o`. The first `frame_o` comes at cycle 8.
- **Single command.** Ch0 sends 0x5A mid-frame. Ready drops the next cycle. The next frame carries 01011010, and ready rises the cycle after the load edge. Other lanes stay idle.
- **Back-to-back.** Ch1 sends 0x11, 0x22, 0x33 with valid held high. Three consecutive frames carry exactly those words, then IDLE_WORD, with no gap between them.
- **Deskew and inversion.** Ch2 dly=3 and ch3 inv=1, both idle. Ch2 matches ch0 shifted by 3 cycles. Ch3 carries 01010011 aligned with ch0.
- **Disable and re-enable.** Ch0 `ch_en=0` with 0x77 valid. Ready is 1, the word is dropped and output stays 0. Re-enable mid-frame: output stays 0 until the next load edge, then sends IDLE_WORD.
- **Reset mid-word.** Assert reset with ch1 hold full and a word half shifted. All outputs are 0 and ready is 0 immediately. After release, `frame_o` comes at cycle 8 with the idle pattern, and the held word is never sent.
